// File: rtl/planes_bus_pkg.sv
// Shared types and constants for the VRAM bus master.
// Holds the FSM state enum, default timing and abort data.
package planes_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    STROBE,
    LATCH,
    RECOVER
  } bus_state_t;

  localparam int TIMEOUT_DEF = 255;
  localparam int RECOV_DEF   = 2;

  localparam logic [7:0] ABORT_DATA = 8'hFF;

endpackage

// File: rtl/bus_wdog.sv
// Acknowledge watchdog: 8-bit counter, cleared outside STROBE.
// Ports: clk, rst_n, clear, run -> expired when count hits LIMIT.
module bus_wdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam logic [7:0] LIM = 8'(LIMIT);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && !expired) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = (cnt == LIM);

endmodule

// File: rtl/vram_bus_master.sv
// Request/response to 68000-style VRAM bus cycle initiator.
// Ports: req_*/rsp_* handshake, AB/nUDS/NREAD/PDS/VRAMCS/DB_* bus.
module vram_bus_master
  import planes_bus_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int RECOV   = RECOV_DEF
) (
  input  logic        clk_24M,
  input  logic        nRES,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic        req_upper,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_timeout,
  output logic [14:0] AB,
  output logic        m68k_addr_16,
  output logic        nUDS,
  output logic        NREAD,
  output logic        PDS,
  output logic        VRAMCS,
  input  logic        VDTAC,
  input  logic [7:0]  DB_IN,
  output logic [7:0]  DB_OUT,
  output logic        DB_OE
);

  localparam logic [2:0] RLAST = 3'(RECOV - 1);

  bus_state_t state, next;

  logic [15:0] addr_q;
  logic        upper_q;
  logic        we_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;
  logic        rsp_valid_q;
  logic        rsp_tmo_q;
  logic [2:0]  rcnt;
  logic        expired;
  logic        accept;
  logic        rec_done;
  logic        to_recover;
  logic        aborting;

  bus_wdog #(
    .LIMIT(TIMEOUT)
  ) u_wdog (
    .clk    (clk_24M),
    .rst_n  (nRES),
    .clear  (state != STROBE),
    .run    (state == STROBE),
    .expired(expired)
  );

  assign accept     = req_valid & req_ready;
  assign rec_done   = (rcnt >= RLAST);
  assign to_recover = (state != RECOVER) && (next == RECOVER);
  assign aborting   = (state == STROBE) && (next == RECOVER);

  always_ff @(posedge clk_24M or negedge nRES) begin
    if (!nRES) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  // Ack wins over a simultaneous watchdog expiry.
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (req_valid) next = ADDR;
      ADDR:    next = STROBE;
      STROBE: begin
        if (!VDTAC) next = LATCH;
        else if (expired) next = RECOVER;
      end
      LATCH:   next = RECOVER;
      RECOVER: if (rec_done && VDTAC) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    PDS       = 1'b0;
    VRAMCS    = 1'b1;
    DB_OE     = 1'b0;
    nUDS      = 1'b1;
    unique case (state)
      IDLE: req_ready = 1'b1;
      ADDR: begin
        DB_OE = we_q;
        nUDS  = ~upper_q;
      end
      STROBE, LATCH: begin
        PDS    = 1'b1;
        VRAMCS = 1'b0;
        DB_OE  = we_q;
        nUDS   = ~upper_q;
      end
      RECOVER: nUDS = ~upper_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk_24M or negedge nRES) begin
    if (!nRES) begin
      addr_q      <= '0;
      upper_q     <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_tmo_q   <= 1'b0;
      rcnt        <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        upper_q <= req_upper;
        we_q    <= req_we;
        if (req_we) wdata_q <= req_wdata;
      end
      if (state == LATCH && !we_q) begin
        rdata_q <= DB_IN;
      end else if (aborting && !we_q) begin
        rdata_q <= ABORT_DATA;
      end
      rsp_valid_q <= to_recover;
      rsp_tmo_q   <= aborting;
      if (state != RECOVER) begin
        rcnt <= '0;
      end else if (rcnt != 3'd7) begin
        rcnt <= rcnt + 3'd1;
      end
    end
  end

  assign AB           = addr_q[14:0];
  assign m68k_addr_16 = addr_q[15];
  assign NREAD        = ~we_q;
  assign DB_OUT       = wdata_q;
  assign rsp_rdata    = rdata_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_timeout  = rsp_tmo_q;

endmodule

// File: doc/vram_bus_master.md
# vram_bus_master

CPU-side bus-cycle initiator for the tile-plane video block. It turns a simple request/response handshake into 68000-style VRAM/character-ROM bus cycles: it drives address, byte lane, direction, the data strobe `PDS` and chip select `VRAMCS`, then waits for the planes block's `VDTAC` acknowledge. It replaces direct CPU core timing in simulation and test harnesses, and serves as the bus front-end for debug and DMA requesters.

## Interface
Parameters:
- `TIMEOUT`, 255: clock cycles in STROBE without `VDTAC` low before the cycle is aborted (1..255).
- `RECOV`, 2: minimum cycles with `PDS` low between bus cycles (1..7).

Ports:
- `clk_24M`  in  1  the single clock; all state is on its rising edge.
- `nRES`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; accept = `req_valid & req_ready`.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  16  word address bits [16:1].
- `req_upper`  in  1  1 = upper byte lane (`nUDS` low), 0 = lower lane.
- `req_wdata`  in  8  write byte.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  8  read byte; held until the next `rsp_valid`.
- `rsp_timeout`  out  1  qualifies `rsp_valid`: the cycle was aborted.
- `AB`  out  15  bus address [15:1].
- `m68k_addr_16`  out  1  bus address bit 16.
- `nUDS`  out  1  upper data strobe, active-low.
- `NREAD`  out  1  1 = read cycle, 0 = write.
- `PDS`  out  1  data strobe, high during a cycle; low holds the acknowledge chain preset.
- `VRAMCS`  out  1  chip select, active-low.
- `VDTAC`  in  1  acknowledge, active-low.
- `DB_IN`  in  8  read data from the planes block (already muxed).
- `DB_OUT`  out  8  write data.
- `DB_OE`  out  1  write-data drive enable.

## Operation
- States: IDLE, ADDR, STROBE, LATCH, RECOVER.
- **IDLE**
  - `PDS=0`, `VRAMCS=1`, `DB_OE=0`.
  - On accept: register addr, lane, we and wdata, drive them onto the bus, go to ADDR.
- **ADDR** (1 cycle): address, `NREAD` and `nUDS` stable; strobes still inactive. For writes, `DB_OE=1` and `DB_OUT=wdata`.
- **STROBE**
  - `PDS=1`, `VRAMCS=0`.
  - Timeout counter counts from 0 each cycle.
  - `VDTAC` sampled 0: go to LATCH.
  - Counter reaches `TIMEOUT`: go to RECOVER with timeout flagged.
- **LATCH** (1 cycle)
  - Strobes are still asserted.
  - Reads: capture `DB_IN` into `rsp_rdata`.
  - Go to RECOVER.
- **RECOVER**
  - `PDS=0`, `VRAMCS=1`, `DB_OE=0`.
  - `rsp_valid` pulses on the first cycle. `rsp_timeout=1` if aborted; an aborted read returns `rsp_rdata=8'hFF`.
  - Stay at least `RECOV` cycles and until `VDTAC` is sampled 1, then go to IDLE.
- Bus outputs hold their last values in IDLE. `nUDS` returns to 1 in IDLE.
- `VDTAC` low in IDLE or ADDR is ignored. No cycle starts until RECOVER has seen `VDTAC` high.
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - Outputs: `PDS=0`, `VRAMCS=1`, `nUDS=1`, `NREAD=1`, `DB_OE=0`.
  - `AB`, `m68k_addr_16`, `DB_OUT` and `rsp_rdata` are all 0. `rsp_valid=0`, `rsp_timeout=0`.
  - No response is issued for a cycle interrupted by reset.

## Timing
- Accept at cycle 0, ADDR at 1, STROBE from 2.
  - `VDTAC` first sampled low at cycle k gives LATCH at k+1 and `rsp_valid` at k+2.
  - Minimum k is 2, so the minimum request-to-response latency is 4 cycles.
- Timeout: with no acknowledge, `rsp_valid` occurs at cycle 2+`TIMEOUT`+1.
- Back-to-back throughput: `req_ready` reasserts at k+2+`RECOV` at the earliest. That is k+4 with the default `RECOV`=2.
- `req_ready` is registered, not combinational from `req_valid`.

## Structure
- Package `planes_bus_pkg` holds:
  - the state enum `bus_state_t`;
  - the default `TIMEOUT` and `RECOV` constants;
  - the `8'hFF` abort-data constant.
- One sub-module, `bus_wdog`: the 8-bit timeout counter with `clear`, `run` and `expired` signals.

## Test plan
- **Write, ack after 3 cycles:** addr `16'h4010`, lower lane, wdata `8'h5A`, `VDTAC` low 3 cycles after `PDS` rises.
  - `AB`=`15'h4010`, `m68k_addr_16`=0, `nUDS`=1, `NREAD`=0.
  - `DB_OUT`=`5A` held from ADDR until RECOVER.
  - `rsp_valid` at cycle 7, `rsp_timeout`=0.
- **Read, upper lane:** addr `16'h8002`, upper lane, `DB_IN`=`8'hC3`, immediate ack.
  - `m68k_addr_16`=1, `nUDS`=0.
  - `rsp_rdata`=`C3` with `rsp_valid` at cycle 4.
- **Timeout:** `TIMEOUT`=4, `VDTAC` held high, read request.
  - `rsp_valid` at cycle 7 with `rsp_timeout`=1 and `rsp_rdata`=`FF`.
  - `PDS` returns to 0.
- **Stuck acknowledge:** `VDTAC` stays low 5 cycles into RECOVER.
  - `req_ready` stays 0 until 1 cycle after `VDTAC` goes high.
  - Recovery lasts no fewer than `RECOV` cycles.
- **Reset mid-cycle:** `nRES` pulsed low during STROBE.
  - `PDS`=0 and `VRAMCS`=1 immediately, without waiting for a clock edge.
  - No `rsp_valid`; `req_ready`=1 on the first edge after release.
- **Back-to-back:** two reads with `req_valid` held high and acks after 1 cycle each.
  - Second `PDS` rise no earlier than `RECOV`+2 cycles after the first falls.
  - Both responses are in order.
